// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter slice.
//   - pc_sel_e : next-PC source select encoding
//   - DEF_INC / DEF_RESET_PC : default sequential increment and reset vector
package pc_pkg;

    localparam logic [31:0] DEF_INC      = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'd0;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst       rising-edge clock, synchronous active-high reset
//   hold           freeze pointer, count, contents and error flag
//   push/pop       push push_data / pop top (pop wins if both)
//   conflict       external request conflict, folded into the sticky error
//   top            entry that the next pop returns
//   empty/full     decoded from the registered count
//   err            sticky: underflow, overflow or conflict seen
module pc_ras #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              push,
    input  logic              pop,
    input  logic              conflict,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;      // next free slot
    logic [PTR_W-1:0]  ptr_dec;  // current top slot
    logic [CNT_W-1:0]  count;

    assign ptr_dec = ptr - PTR_W'(1);
    assign top     = mem[ptr_dec];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));

    // When full, the slot at ptr holds the oldest entry, so a push simply
    // overwrites it while the count saturates.
    always_ff @(posedge clk) begin
        if (!rst && !hold && push && !pop) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (!hold) begin
            if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    ptr   <= ptr_dec;
                    count <= count - CNT_W'(1);
                end
            end else if (push) begin
                ptr <= ptr + PTR_W'(1);
                if (full) begin
                    err <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (conflict) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter register with five-way next-PC select and a
// return-address stack.
//   CLK, RESET     rising-edge clock, synchronous active-high reset
//   STALL          hold PC and RAS, ignore requests
//   BR_TAKEN       branch taken; BR_OFFSET is the sign-extended byte offset
//   JUMP / CALL    go to JUMP_TARGET (CALL also pushes PC+INC)
//   RET            pop and go to the return address
//   PC, PC_PLUS    registered PC and PC+INC
//   RAS_EMPTY/FULL stack occupancy flags
//   RAS_ERR        sticky underflow / overflow / conflict flag
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  INC       = ADDR_W'(DEF_INC),
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_OFFSET,
    input  logic              JUMP,
    input  logic              CALL,
    input  logic              RET,
    input  logic [ADDR_W-1:0] JUMP_TARGET,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_PLUS,
    output logic              RAS_EMPTY,
    output logic              RAS_FULL,
    output logic              RAS_ERR
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] ras_top;
    pc_sel_e           sel;
    logic              conflict;
    logic              ras_push;
    logic              ras_pop;

    assign PC        = pc_q;
    assign PC_PLUS   = pc_q + INC;
    assign br_target = PC_PLUS + BR_OFFSET;

    // BR_TAKEN alongside a jump-class request is a normal override, not an error.
    assign conflict = !STALL && ((RET && CALL) || (RET && JUMP) || (CALL && JUMP));
    assign ras_push = !STALL && (sel == SEL_CALL);
    assign ras_pop  = !STALL && (sel == SEL_RET);

    always_comb begin
        sel = SEL_SEQ;
        if (RET) begin
            sel = SEL_RET;
        end else if (CALL) begin
            sel = SEL_CALL;
        end else if (JUMP) begin
            sel = SEL_JMP;
        end else if (BR_TAKEN) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = PC_PLUS;
        case (sel)
            SEL_BR:   pc_next = br_target;
            SEL_JMP:  pc_next = JUMP_TARGET;
            SEL_CALL: pc_next = JUMP_TARGET;
            // Underflowing return falls through to the sequential address.
            SEL_RET:  pc_next = RAS_EMPTY ? PC_PLUS : ras_top;
            default:  pc_next = PC_PLUS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else if (!STALL) begin
            pc_q <= pc_next;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst       (RESET),
        .hold      (STALL),
        .push      (ras_push),
        .pop       (ras_pop),
        .conflict  (conflict),
        .push_data (PC_PLUS),
        .top       (ras_top),
        .empty     (RAS_EMPTY),
        .full      (RAS_FULL),
        .err       (RAS_ERR)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven bench for pc_unit with a scoreboard queue of
// expected post-edge states.
module tb_pc_unit;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_OFFSET;
    logic        JUMP;
    logic        CALL;
    logic        RET;
    logic [31:0] JUMP_TARGET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS;
    logic        RAS_EMPTY;
    logic        RAS_FULL;
    logic        RAS_ERR;

    pc_unit #(
        .ADDR_W    (32),
        .INC       (32'd4),
        .RESET_PC  (32'd0),
        .RAS_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .STALL       (STALL),
        .BR_TAKEN    (BR_TAKEN),
        .BR_OFFSET   (BR_OFFSET),
        .JUMP        (JUMP),
        .CALL        (CALL),
        .RET         (RET),
        .JUMP_TARGET (JUMP_TARGET),
        .PC          (PC),
        .PC_PLUS     (PC_PLUS),
        .RAS_EMPTY   (RAS_EMPTY),
        .RAS_FULL    (RAS_FULL),
        .RAS_ERR     (RAS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] off;
        logic        jump;
        logic        call;
        logic        ret;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        err;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[25];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] off,
                                logic jump, logic call, logic ret, logic [31:0] tgt,
                                logic [31:0] pc, logic e, logic f, logic err);
        vec_t v;
        v.rst = rst;   v.stall = stall; v.br = br;     v.off = off;
        v.jump = jump; v.call = call;   v.ret = ret;   v.tgt = tgt;
        v.pc = pc;     v.e = e;         v.f = f;       v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s actual=%h required=%h", step_no, name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge CLK);
        RESET = v.rst;  STALL = v.stall; BR_TAKEN = v.br; BR_OFFSET = v.off;
        JUMP = v.jump;  CALL = v.call;   RET = v.ret;     JUMP_TARGET = v.tgt;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step %0d scoreboard empty", step_no);
        end else begin
            e = sb.pop_front();
            chk("pc",        PC,                 e.pc);
            chk("pc_plus",   PC_PLUS,            e.pc + 32'd4);
            chk("ras_empty", {31'd0, RAS_EMPTY}, {31'd0, e.e});
            chk("ras_full",  {31'd0, RAS_FULL},  {31'd0, e.f});
            chk("ras_err",   {31'd0, RAS_ERR},   {31'd0, e.err});
        end
        step_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_OFFSET = '0;
        JUMP = 1'b0;  CALL = 1'b0;  RET = 1'b0;      JUMP_TARGET = '0;

        //            rst st br off           j  c  r  tgt            pc           e  f  err
        tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h4,        1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h8,        1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hC,        1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h10,       32'h10,       1, 0, 0);
        tbl[5]  = mk(0, 1, 1, 32'hFFFFFFF0, 0, 0, 0, 32'h0,        32'h10,       1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 32'hFFFFFFF0, 0, 0, 0, 32'h0,        32'h04,       1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h20,       32'h20,       1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h100,      32'h100,      0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h104,      0, 0, 0);
        tbl[10] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h108,      0, 0, 0);
        tbl[11] = mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h0,        32'h108,      0, 0, 0);
        tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h24,       1, 0, 0);
        tbl[13] = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h40,       32'h40,       1, 0, 0);
        tbl[14] = mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h44,       1, 0, 1);
        tbl[15] = mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h300,      32'h0,        1, 0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0, 0);
        tbl[18] = mk(0, 0, 1, 32'hFFFFFFF8, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h80,       32'h80,       0, 0, 1);
        tbl[20] = mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        1, 0, 1);
        tbl[21] = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0, 0);
        tbl[22] = mk(0, 0, 1, 32'h1000,     1, 0, 0, 32'h50,       32'h50,       1, 0, 0);
        tbl[23] = mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h200,      32'h54,       1, 0, 1);
        tbl[24] = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i]);
        end

        // Overflow sequence: five calls into a four-deep stack, then unwind.
        step(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h100, 32'h100, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h200, 32'h200, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h300, 32'h300, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h400, 32'h400, 0, 1, 0));
        step(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h500, 32'h500, 0, 1, 1));
        step(mk(0, 1, 0, 32'h0, 0, 0, 1, 32'h0,   32'h500, 0, 1, 1));
        step(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0,   32'h404, 0, 0, 1));
        step(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0,   32'h304, 0, 0, 1));
        step(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0,   32'h204, 0, 0, 1));
        step(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0,   32'h104, 1, 0, 1));
        step(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0,   32'h108, 1, 0, 1));
        step(mk(1, 1, 0, 32'h0, 0, 0, 1, 32'h0,   32'h0,   1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the 2:1 PC select mux: holds the program counter register and selects the next PC from five sources.
- Sources: sequential, branch, jump, call, return. Includes a return-address stack (RAS) for call/return.
- Sits between the control unit / ALU branch logic and instruction memory. PC drives the instruction fetch address directly.

Parameters:
- ADDR_W, 32, width of PC, offsets and targets.
- INC, 4, sequential increment in bytes.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  hold PC and RAS this cycle.
- BR_TAKEN  in  1  branch resolved taken (already ANDed with condition).
- BR_OFFSET  in  ADDR_W  signed byte offset, already sign-extended.
- JUMP  in  1  absolute jump.
- CALL  in  1  jump and push return address.
- RET  in  1  pop return address and jump to it.
- JUMP_TARGET  in  ADDR_W  absolute target for JUMP/CALL.
- PC  out  ADDR_W  current PC (registered).
- PC_PLUS  out  ADDR_W  PC+INC (combinational from PC).
- RAS_EMPTY  out  1  stack holds 0 entries.
- RAS_FULL  out  1  stack holds RAS_DEPTH entries.
- RAS_ERR  out  1  sticky: underflow, overflow or conflicting request seen.

Behaviour:
- Clock and reset: one clock CLK; reset RESET is synchronous and active-high.
- Reset values: at a rising edge with RESET=1, PC=RESET_PC, RAS count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0. RESET overrides STALL and all requests, including mid-call sequences.
- PC changes only on the CLK rising edge. The selected next PC is visible on PC one cycle after the request.
- STALL=1 (no RESET): PC, RAS contents, count and RAS_ERR hold; all requests ignored.
- Next-PC priority when not stalled: RET > CALL > JUMP > BR_TAKEN > sequential.
  - RET: PC = top of stack; pop.
  - CALL: push PC+INC; PC = JUMP_TARGET.
  - JUMP: PC = JUMP_TARGET.
  - BR_TAKEN: PC = PC + INC + BR_OFFSET.
  - Otherwise: PC = PC + INC.
- Arithmetic: all sums are modulo 2^ADDR_W. Wrap-around is silent and no flag is raised.
- Conflicts: more than one of {RET, CALL, JUMP} asserted in the same cycle → the highest-priority request is executed, lower ones are dropped, and RAS_ERR is set. BR_TAKEN with any of these is not an error; it is simply overridden.
- RAS underflow: RET while empty → PC = PC+INC, count stays 0, RAS_ERR set.
- RAS overflow: CALL while full → circular overwrite of the oldest entry; count stays RAS_DEPTH; RAS_ERR set. The new return address is still pushed.
- RAS_ERR clears only on RESET.
- RAS_EMPTY and RAS_FULL are decoded from the registered count, so they are valid the cycle after the push/pop.

Decomposition:
- Shared package pc_pkg:
  - next-PC source select encoding: SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET.
  - default RESET_PC and INC constants.
- Sub-module pc_ras: circular stack with top pointer and count, push/pop/hold inputs, top, empty, full, err outputs.
- The PC register, priority encoder and adders live in pc_unit.

Test Plan:
- Reset then 3 free-running cycles → PC = 0, 4, 8, 12; RAS_EMPTY=1; RAS_ERR=0.
- PC=0x10, BR_TAKEN=1, BR_OFFSET=0xFFFFFFF0 (-16) → next PC = 0x04; with STALL=1 held for the same cycle, PC stays 0x10.
- PC=0x20, CALL=1, JUMP_TARGET=0x100 → PC=0x100, RAS_EMPTY=0. Then 2 sequential cycles, then RET=1 → PC=0x24, RAS_EMPTY=1.
- Five CALLs (DEPTH=4) at PCs 0x0,0x100,0x200,0x300,0x400, each targeting PC+0x100 → RAS_FULL=1, RAS_ERR=1. Four RETs → PC = 0x404, 0x304, 0x204, 0x104; 0x004 was overwritten.
- RET on empty stack at PC=0x40 → PC=0x44, RAS_ERR=1. A following RESET → PC=0, RAS_ERR=0.
- PC=0xFFFFFFFC sequential → PC=0x00000000. JUMP+CALL same cycle (target 0x80) → PC=0x80, one entry pushed, RAS_ERR=1.
